clk_counter_leds_top: RTL and testbench
=======================================

Name: clk_counter_leds_top

Overview:
Top-level demo block for the DE0-Nano board. It divides the 50 MHz board clock down to a 5 Hz tick. On each tick it advances a binary counter shown on the green LEDs. The top LED flags counter wrap-around. KEY[0] is the board reset and KEY[1] is a hold-to-run enable; both push-buttons are active-low.

Parameters:
- EXT_CLOCK_FREQ, 50000000, input clock frequency in Hz.
- EXT_CLOCK_PERIOD, 20.0, clock period in ns (real). Informational only; no logic depends on it.
- LEDG_SIZE, 8, number of green LEDs driven.
- Derived localparam LED_CNTR_WIDTH = LEDG_SIZE-1 = 7.
- Derived localparam COUNT_FREQ = EXT_CLOCK_FREQ/5 = 10,000,000 clocks per LED step (0.2 s).
- Derived localparam COUNT_WIDTH = $clog2(COUNT_FREQ).

Ports:
- EXTCLK  input  1  board clock; all logic is on its rising edge.
- KEY  input  2  push-buttons, active-low.
  - KEY[0] is the asynchronous active-low reset.
  - KEY[1] is the active-low count enable (0 = count, 1 = hold).
- LEDG  output  LEDG_SIZE  LED outputs.
  - LEDG[LEDG_SIZE-2:0] = led_counter.
  - LEDG[LEDG_SIZE-1] = overflow flag.

Behaviour:
- Reset:
  - KEY[0]=0 asynchronously clears clk_counter, led_counter and the overflow flag. LEDG=0x00 while reset is held.
  - Release takes effect on the next EXTCLK edge.
  - Reset asserted mid-period discards the partial clk_counter count.
- Internal registers. These names are fixed because benches reference them hierarchically:
  - clk_counter [COUNT_WIDTH-1:0], the prescaler.
  - led_counter [LED_CNTR_WIDTH-1:0], the displayed value.
  - overflow, 1 bit.
- Enable:
  - en = ~KEY[1], used directly with no synchronizer or debounce. Toggling KEY[1] has zero-cycle effect.
  - While en=0, clk_counter and led_counter hold their values.
- Prescaler: each enabled clock:
  - If clk_counter == COUNT_FREQ-1, clk_counter becomes 0 and a tick is generated.
  - Otherwise clk_counter increments by 1.
- LED counter:
  - On a tick, led_counter increments modulo 2^LED_CNTR_WIDTH.
  - The first increment after reset with en=1 appears exactly COUNT_FREQ enabled clocks after release.
  - Each later increment follows after another COUNT_FREQ enabled clocks.
  - Paused clocks do not count toward the period; the prescaler resumes from its held value.
- Overflow:
  - Registered single-cycle pulse. overflow=1 for exactly one clock, in the same cycle led_counter shows 0x00 after wrapping from 0x7F.
  - It is 0 in every other cycle, including while paused.
  - A tick that does not wrap sets overflow=0.
- Outputs are registered. LEDG is a pure concatenation {overflow, led_counter} with no extra latency.
- Forcing both internal counters and then releasing them resumes normal counting from the forced values.

Test Plan:
- Hold KEY[0]=0 for 10 clocks, then release -> LEDG=0x00.
- KEY[1]=1 for 2*COUNT_FREQ clocks after reset -> LEDG stays 0x00.
- KEY[1]=0 -> LEDG[6:0]=0x01 after COUNT_FREQ clocks, then 0x02..0x05 after each further COUNT_FREQ clocks; LEDG[7]=0 throughout.
- Pause at value N via KEY[1]=1 for 3*COUNT_FREQ clocks -> LEDG holds N. Resume -> N+1 after at most COUNT_FREQ more clocks.
- Assert reset for 5 clocks mid-period (COUNT_FREQ/2 in) -> LEDG=0x00. The next step to 0x01 comes exactly COUNT_FREQ clocks after release.
- Force led_counter=0x7C and clk_counter=0, then count:
  - LEDG[6:0] steps 0x7D, 0x7E, 0x7F.
  - Next tick gives LEDG=0x80 for exactly one clock, then 0x00.
  - Counting continues 0x01..0x03.

Source files
------------

// File: rtl/clk_counter_leds_top.sv
// DE0-Nano LED demo: divides EXTCLK down to a 5 Hz step and shows a binary
// count on the green LEDs, with the top LED pulsing once per wrap-around.
module clk_counter_leds_top #(
    parameter int  EXT_CLOCK_FREQ   = 50000000,
    parameter real EXT_CLOCK_PERIOD = 20.0,
    parameter int  LEDG_SIZE        = 8
) (
    input  logic                 EXTCLK,
    input  logic [1:0]           KEY,
    output logic [LEDG_SIZE-1:0] LEDG
);

    localparam int LED_CNTR_WIDTH = LEDG_SIZE - 1;
    localparam int COUNT_FREQ     = EXT_CLOCK_FREQ / 5;
    localparam int COUNT_WIDTH    = $clog2(COUNT_FREQ);

    localparam logic [COUNT_WIDTH-1:0]    COUNT_MAX = COUNT_WIDTH'(COUNT_FREQ - 1);
    localparam logic [LED_CNTR_WIDTH-1:0] LED_MAX   = '1;

    logic rst_n;
    logic en;
    logic tick;

    logic [COUNT_WIDTH-1:0]    clk_counter;
    logic [COUNT_WIDTH-1:0]    clk_counter_d;
    logic [LED_CNTR_WIDTH-1:0] led_counter;
    logic [LED_CNTR_WIDTH-1:0] led_counter_d;
    logic                      overflow;
    logic                      overflow_d;

    // Push-buttons are active-low; enable is used raw, without synchronizer.
    assign rst_n = KEY[0];
    assign en    = ~KEY[1];
    assign tick  = (clk_counter == COUNT_MAX);

    always_comb begin
        clk_counter_d = clk_counter;
        led_counter_d = led_counter;
        overflow_d    = 1'b0;
        if (en) begin
            if (tick) begin
                clk_counter_d = '0;
                led_counter_d = led_counter + 1'b1;
                overflow_d    = (led_counter == LED_MAX);
            end else begin
                clk_counter_d = clk_counter + 1'b1;
            end
        end
    end

    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) begin
            clk_counter <= '0;
            led_counter <= '0;
            overflow    <= 1'b0;
        end else begin
            clk_counter <= clk_counter_d;
            led_counter <= led_counter_d;
            overflow    <= overflow_d;
        end
    end

    assign LEDG = {overflow, led_counter};

endmodule

// File: tb/tb_clk_counter_leds_top.sv
// Directed bench for clk_counter_leds_top, run with a 10-clock LED step.
module tb_clk_counter_leds_top;

    localparam int CF = 10;

    logic       clk;
    logic [1:0] key;
    logic [7:0] ledg;

    int checks;
    int errors;

    clk_counter_leds_top #(
        .EXT_CLOCK_FREQ  (CF * 5),
        .EXT_CLOCK_PERIOD(20.0),
        .LEDG_SIZE       (8)
    ) dut (
        .EXTCLK(clk),
        .KEY   (key),
        .LEDG  (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        key = 2'b10;
        tick(10);
        check("reset_held", ledg, 8'h00);
        key = 2'b11;
        tick(1);
        check("reset_release", ledg, 8'h00);

        tick(2 * CF);
        check("hold_after_reset", ledg, 8'h00);
        check("hold_prescaler", 8'(dut.clk_counter), 8'h00);

        key = 2'b01;
        tick(CF - 1);
        check("first_step_early", ledg, 8'h00);
        tick(1);
        check("first_step", ledg, 8'h01);
        for (int v = 2; v <= 5; v++) begin
            tick(CF);
            check("count_step", ledg, 8'(v));
        end

        tick(3);
        key = 2'b11;
        tick(3 * CF);
        check("pause_hold", ledg, 8'h05);
        check("pause_prescaler", 8'(dut.clk_counter), 8'h03);
        key = 2'b01;
        tick(CF - 4);
        check("resume_early", ledg, 8'h05);
        tick(1);
        check("resume_step", ledg, 8'h06);

        tick(CF / 2);
        key = 2'b00;
        #1;
        check("reset_async", ledg, 8'h00);
        tick(5);
        check("reset_mid_period", ledg, 8'h00);
        key = 2'b01;
        tick(CF - 1);
        check("post_reset_early", ledg, 8'h00);
        tick(1);
        check("post_reset_step", ledg, 8'h01);

        force dut.led_counter = 7'h7C;
        force dut.clk_counter = '0;
        #1;
        release dut.led_counter;
        release dut.clk_counter;
        check("forced_value", ledg, 8'h7C);
        tick(CF - 1);
        check("forced_hold", ledg, 8'h7C);
        tick(1);
        check("step_7d", ledg, 8'h7D);
        tick(CF);
        check("step_7e", ledg, 8'h7E);
        tick(CF);
        check("step_7f", ledg, 8'h7F);
        tick(CF - 1);
        check("pre_wrap", ledg, 8'h7F);
        tick(1);
        check("wrap_overflow", ledg, 8'h80);
        tick(1);
        check("overflow_clear", ledg, 8'h00);
        tick(CF - 2);
        check("after_wrap_hold", ledg, 8'h00);
        tick(1);
        check("after_wrap_01", ledg, 8'h01);
        tick(CF);
        check("after_wrap_02", ledg, 8'h02);
        tick(CF);
        check("after_wrap_03", ledg, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
